branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 91 +++++++++
 tb/tb_branch_predictor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, combinational lookup and
// misprediction detection, plus resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_br,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    // Word-aligned PCs: the byte offset never selects or tags an entry.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^upd_pc[1:0];

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Lookup reads the registered arrays, so a same-cycle update is not visible yet.
    assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken   = if_hit && ctr_q[if_idx][1];
    assign pred_next_pc = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mispredict = upd_valid &&
                        ((upd_br != upd_pred_taken) ||
                         (upd_br && (upd_pred_target != upd_target)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, giving read-before-write behaviour for free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            br_count   <= '0;
            miss_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'd0;
            end
        end else if (upd_valid) begin
            br_count <= br_count + 32'd1;
            if (mispredict) begin
                miss_count <= miss_count + 32'd1;
            end
            if (upd_hit) begin
                if (upd_br && ctr_q[upd_idx] != 2'd3) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                end else if (!upd_br && ctr_q[upd_idx] != 2'd0) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_br) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= 2'd2;
            end
        end
    end

    // NOTE: tag/target storage is deliberately left out of reset; the cleared
    // valid bits already mask whatever these arrays hold.
    always_ff @(posedge clk) begin
        if (rst_n && upd_valid && upd_br) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed expectations for reset,
// allocation, hysteresis, aliasing, read-before-write and mid-run reset.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_br;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int vectors     = 0;
    int miscompares = 0;

    branch_predictor #(.ENTRIES(64), .IDX_W(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_next_pc    (pred_next_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_br          (upd_br),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .br_count        (br_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_br          = br;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_tk,
                          input logic [31:0] exp_npc);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, 32'(pred_taken), 32'(exp_tk));
        check({tag, "_npc"}, pred_next_pc, exp_npc);
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_br = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;

        // Reset and cold lookup
        tick();
        lookup("in_reset", 32'h100, 1'b0, 32'h104);
        tick();
        rst_n = 1'b1;
        lookup("cold", 32'h100, 1'b0, 32'h104);
        check("cold_br", br_count, 32'd0);
        check("cold_miss", miss_count, 32'd0);

        // Allocation: taken miss, counter becomes 2
        upd(1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        #1;
        check("alloc_mispredict", 32'(mispredict), 32'd1);
        lookup("alloc_same_cycle", 32'h100, 1'b0, 32'h104);
        tick();
        upd_valid = 1'b0;
        lookup("alloc_next", 32'h100, 1'b1, 32'h80);
        check("alloc_br", br_count, 32'd1);
        check("alloc_miss", miss_count, 32'd1);

        // Not-taken from counter 2: same cycle still taken, then 1
        upd(1'b0, 32'h100, 32'h0, 1'b1, 32'h80);
        lookup("rbw_same_cycle", 32'h100, 1'b1, 32'h80);
        check("nt_mispredict", 32'(mispredict), 32'd1);
        tick();
        upd_valid = 1'b0;
        lookup("ctr1", 32'h100, 1'b0, 32'h104);

        // Two taken updates -> counter 3
        upd(1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        tick();
        upd(1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
        #1;
        check("correct_pred", 32'(mispredict), 32'd0);
        tick();
        upd_valid = 1'b0;
        lookup("ctr3", 32'h100, 1'b1, 32'h80);

        // One not-taken from 3 -> still taken
        upd(1'b0, 32'h100, 32'h0, 1'b1, 32'h80);
        tick();
        upd_valid = 1'b0;
        lookup("ctr2_hyst", 32'h100, 1'b1, 32'h80);
        check("hyst_br", br_count, 32'd5);
        check("hyst_miss", miss_count, 32'd4);

        // Taken hit with a different target: target mismatch mispredicts, target overwritten
        upd(1'b1, 32'h100, 32'h90, 1'b1, 32'h80);
        #1;
        check("tgt_mispredict", 32'(mispredict), 32'd1);
        tick();
        upd_valid = 1'b0;
        lookup("tgt_new", 32'h100, 1'b1, 32'h90);

        // upd_valid low: other upd_* ignored, no mispredict, no count
        upd(1'b1, 32'h100, 32'h55, 1'b0, 32'h0);
        upd_valid = 1'b0;
        #1;
        check("idle_mispredict", 32'(mispredict), 32'd0);
        tick();
        lookup("idle_table", 32'h100, 1'b1, 32'h90);
        check("idle_br", br_count, 32'd6);

        // Not-taken miss at the same index leaves the table alone
        upd(1'b0, 32'h300, 32'h0, 1'b0, 32'h304);
        #1;
        check("ntmiss_mispredict", 32'(mispredict), 32'd0);
        tick();
        upd_valid = 1'b0;
        lookup("ntmiss_300", 32'h300, 1'b0, 32'h304);
        lookup("ntmiss_100", 32'h100, 1'b1, 32'h90);
        check("ntmiss_br", br_count, 32'd7);
        check("ntmiss_miss", miss_count, 32'd5);

        // Aliasing: 0x200 replaces 0x100 at index 0
        upd(1'b1, 32'h200, 32'h40, 1'b0, 32'h204);
        tick();
        upd_valid = 1'b0;
        lookup("alias_100", 32'h100, 1'b0, 32'h104);
        lookup("alias_200", 32'h200, 1'b1, 32'h40);
        lookup("wrap_pc", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        check("alias_miss", miss_count, 32'd6);

        // Reset mid-operation with a simultaneous update
        rst_n = 1'b0;
        upd(1'b1, 32'h200, 32'h44, 1'b0, 32'h204);
        #1;
        check("reset_mispredict", 32'(mispredict), 32'd1);
        tick();
        rst_n = 1'b1;
        upd_valid = 1'b0;
        lookup("post_reset_200", 32'h200, 1'b0, 32'h204);
        lookup("post_reset_100", 32'h100, 1'b0, 32'h104);
        check("post_reset_br", br_count, 32'd0);
        check("post_reset_miss", miss_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
